sram_req_arbiter: RTL

//  Shares one SRAM-like memory port between the fetch-stage (inst) and execute-stage (data) requesters.

---
 rtl/sram_req_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
// Arbitrates the fetch (inst) and execute (data) SRAM-like request ports onto one downstream port.
// Optional macro ARB_ROUND_ROBIN_EN selects alternating arbitration instead of data priority with anti-starvation.
module sram_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_e;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                m_wr_q, m_wr_d;
    logic [1:0]          m_size_q, m_size_d;
    logic [3:0]          m_wstrb_q, m_wstrb_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                grant_data;
    logic                grant_now;

    assign grant_now = (state_q == S_IDLE) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (i_req && d_req) grant_data = (last_q == OWN_INST);
        else                grant_data = d_req;
        if (grant_now) last_d = grant_data ? OWN_DATA : OWN_INST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= OWN_INST;
        else       last_q <= last_d;
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    // Counter only advances while inst is waiting, so it saturates at STARVE_LIMIT and then forces an inst grant.
    always_comb begin
        starve_d = starve_q;
        if (i_req && d_req) grant_data = (starve_q != CNT_W'(STARVE_LIMIT));
        else                grant_data = d_req;
        if (grant_now) starve_d = (grant_data && i_req) ? starve_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_wr_d    = m_wr_q;
        m_size_d  = m_size_q;
        m_wstrb_d = m_wstrb_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    state_d = S_ADDR;
                    if (grant_data) begin
                        owner_d   = OWN_DATA;
                        m_wr_d    = d_wr;
                        m_size_d  = d_size;
                        m_wstrb_d = d_wstrb;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        owner_d   = OWN_INST;
                        m_wr_d    = i_wr;
                        m_size_d  = i_size;
                        m_wstrb_d = i_wstrb;
                        m_addr_d  = i_addr;
                        m_wdata_d = i_wdata;
                    end
                end
            end
            S_ADDR:  if (m_addr_ok) state_d = S_DATA;
            S_DATA:  if (m_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_DATA;
            m_wr_q    <= 1'b0;
            m_size_q  <= '0;
            m_wstrb_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_wr_q    <= m_wr_d;
            m_size_q  <= m_size_d;
            m_wstrb_q <= m_wstrb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Handshake pulses are combinational so the owner sees them in the same cycle as the downstream strobe.
    assign m_req     = (state_q == S_ADDR);
    assign i_addr_ok = m_req && m_addr_ok && (owner_q == OWN_INST);
    assign d_addr_ok = m_req && m_addr_ok && (owner_q == OWN_DATA);
    assign i_data_ok = (state_q == S_DATA) && m_data_ok && (owner_q == OWN_INST);
    assign d_data_ok = (state_q == S_DATA) && m_data_ok && (owner_q == OWN_DATA);
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;
    assign m_wr      = m_wr_q;
    assign m_size    = m_size_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule
